// File: rtl/plic_arb_round_ctrl_pkg.sv
// Shared definitions for the PLIC round sequencer: default sizing, state
// encodings and the round-count derivation also used by the 32-to-1 arbiter.
package plic_arb_round_ctrl_pkg;

    localparam int INT_NUM_DEF     = 1024;
    localparam int ECH_RD_DEF      = 32;
    localparam int ID_NUM_DEF      = 10;
    localparam int PRIO_BIT_DEF    = 5;
    localparam int ROUND_WIDTH_DEF = 5;
    localparam int ARB_LAT_DEF     = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SWEEP = 2'b01,
        ST_DRAIN = 2'b10
    } arb_state_e;

    // Number of rounds needed to cover every source.
    function automatic int round_num(input int int_num, input int ech_rd);
        return int_num / ech_rd;
    endfunction

endpackage

// File: rtl/plic_arb_round_ctrl.sv
// Round sequencer behind the PLIC 32-to-1 arbiter: walks every round, waits
// out the arbiter pipeline, captures the winner and applies the hart threshold.
module plic_arb_round_ctrl
    import plic_arb_round_ctrl_pkg::*;
#(
    parameter int INT_NUM     = INT_NUM_DEF,
    parameter int ECH_RD      = ECH_RD_DEF,
    parameter int ID_NUM      = ID_NUM_DEF,
    parameter int PRIO_BIT    = PRIO_BIT_DEF,
    parameter int ROUND_WIDTH = ROUND_WIDTH_DEF,
    parameter int ARB_LAT     = ARB_LAT_DEF
) (
    input  logic                   arb_clk,
    input  logic                   plicrst,
    input  logic                   ctrl_arb_trigger,
    input  logic                   ctrl_claim_vld,
    input  logic [PRIO_BIT-1:0]    ctrl_threshold,
    input  logic                   arb_int_req,
    input  logic [ID_NUM-1:0]      arb_int_id,
    input  logic [PRIO_BIT-1:0]    arb_int_prio,
    output logic [ROUND_WIDTH-1:0] int_select_round,
    output logic                   ctrl_arb_new_arb_start,
    output logic                   arb_busy,
    output logic                   arb_done,
    output logic                   hart_int_req,
    output logic [ID_NUM-1:0]      hart_int_id,
    output logic [PRIO_BIT-1:0]    hart_int_prio
);

    localparam int                     ROUND      = round_num(INT_NUM, ECH_RD);
    localparam logic [ROUND_WIDTH-1:0] LAST_ROUND = ROUND_WIDTH'(ROUND - 1);
    localparam logic [ROUND_WIDTH-1:0] LAST_DRAIN = ROUND_WIDTH'(ARB_LAT - 1);

    arb_state_e             state_q, state_d;
    logic [ROUND_WIDTH-1:0] cnt_q, cnt_d;       // round index in SWEEP, drain index in DRAIN
    logic                   pending_q, pending_d;
    logic                   capture;
    logic [ROUND_WIDTH-1:0] select_q;
    logic                   done_q;
    logic                   req_q;
    logic [ID_NUM-1:0]      id_q;
    logic [PRIO_BIT-1:0]    prio_q;

    // Next-state, counter and pending-flag logic; claim overrides everything.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        capture   = 1'b0;
        if (ctrl_claim_vld) begin
            state_d   = ST_SWEEP;
            cnt_d     = '0;
            pending_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ctrl_arb_trigger || pending_q) begin
                        state_d   = ST_SWEEP;
                        cnt_d     = '0;
                        pending_d = 1'b0;
                    end
                end
                ST_SWEEP: begin
                    pending_d = pending_q | ctrl_arb_trigger;
                    if (cnt_q == LAST_ROUND) begin
                        state_d = ST_DRAIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ROUND_WIDTH'(1);
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q == LAST_DRAIN) begin
                        capture = 1'b1;
                        cnt_d   = '0;
                        // A trigger landing in the capture cycle still earns a sweep.
                        if (pending_q || ctrl_arb_trigger) begin
                            state_d   = ST_SWEEP;
                            pending_d = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d     = cnt_q + ROUND_WIDTH'(1);
                        pending_d = pending_q | ctrl_arb_trigger;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter and registered round select.
    always_ff @(posedge arb_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (plicrst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            select_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            case (state_d)
                ST_SWEEP: select_q <= cnt_d;
                ST_DRAIN: select_q <= LAST_ROUND;
                default:  select_q <= '0;
            endcase
        end
    end

    // Capture of the arbiter winner and threshold compare; claim drops the request.
    always_ff @(posedge arb_clk) begin
        if (plicrst) begin
            done_q <= 1'b0;
            req_q  <= 1'b0;
            id_q   <= '0;
            prio_q <= '0;
        end else begin
            done_q <= capture;
            if (capture) begin
                id_q   <= arb_int_id;
                prio_q <= arb_int_prio;
                req_q  <= arb_int_req && (arb_int_prio > ctrl_threshold);
            end else if (ctrl_claim_vld) begin
                req_q  <= 1'b0;
            end
        end
    end

    assign int_select_round       = select_q;
    assign ctrl_arb_new_arb_start = (state_q == ST_SWEEP) && (cnt_q == '0);
    assign arb_busy               = (state_q != ST_IDLE);
    assign arb_done               = done_q;
    assign hart_int_req           = req_q;
    assign hart_int_id            = id_q;
    assign hart_int_prio          = prio_q;

endmodule
